// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and baud timing helpers.
// Used by both receiver and transmitter; parity support is selected with UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Clocks per serial bit (integer division, matches the transmitter).
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned baud_rate);
    return clk_fre / baud_rate;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_fre,
                                            input int unsigned baud_rate);
    return calc_cycle(clk_fre, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line (resets to idle-high)
// with a registered previous value for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx_pin,
  output logic o_rx_s,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a one-entry valid/ready output register, framing
// error and overrun pulses. Define UART_RX_PARITY_EN for 8E1 with parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FRE   = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] dout,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CYCLE = int'(calc_cycle(CLK_FRE, BAUD_RATE));
  localparam int HALF  = int'(calc_half(CLK_FRE, BAUD_RATE));
  localparam int CW    = $clog2(CYCLE) + 1;
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CYCLE - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

  logic w_rx_s;
  logic w_fall;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_rx_pin (rx_pin),
    .o_rx_s   (w_rx_s),
    .o_fall   (w_fall)
  );

  uart_state_e   r_state;
  uart_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitpos;
  logic [7:0]    r_shift;
  logic [7:0]    r_dout;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          w_cnt_clr;
  logic          w_start_ok;
  logic          w_sample_bit;
  logic          w_stop_sample;
  logic          w_par_bad;
  logic          w_byte_good;
`ifdef UART_RX_PARITY_EN
  logic          w_sample_par;
  logic          r_par_bit;
  logic          r_parity_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_start_ok    = 1'b0;
    w_sample_bit  = 1'b0;
    w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_sample_par  = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        // A start bit that is high again at mid-period was only a glitch.
        if (r_cnt == CNT_HALF_END) begin
          w_cnt_clr   = 1'b1;
          w_start_ok  = ~w_rx_s;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == CNT_BIT_END) begin
          w_cnt_clr    = 1'b1;
          w_sample_bit = 1'b1;
          if (r_bitpos == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == CNT_BIT_END) begin
          w_cnt_clr    = 1'b1;
          w_sample_par = 1'b1;
          w_state_nxt  = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
        if (r_cnt == CNT_BIT_END) begin
          w_cnt_clr     = 1'b1;
          w_stop_sample = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = ^{r_shift, r_par_bit};
`else
  assign w_par_bad = 1'b0;
`endif
  assign w_byte_good = w_stop_sample & w_rx_s & ~w_par_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bitpos    <= 3'd0;
      r_shift     <= 8'h00;
      r_dout      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      r_frame_err <= w_stop_sample & ~w_rx_s;
      r_overrun   <= 1'b0;
      if (w_start_ok)        r_bitpos <= 3'd0;
      else if (w_sample_bit) r_bitpos <= r_bitpos + 3'd1;
      if (w_sample_bit) r_shift[r_bitpos] <= w_rx_s;
      // A completing byte may replace dout only if the old one is gone or leaving now.
      if (w_byte_good) begin
        if (!r_valid || rx_ready) begin
          r_dout  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (w_sample_par) r_par_bit <= w_rx_s;
      r_parity_err <= w_stop_sample & w_par_bad;
    end
  end

  assign parity_err = r_parity_err;
`endif

  assign dout      = r_dout;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_FRE=1 MHz, BAUD_RATE=100 kbaud (10 clocks/bit).
// Build with UART_RX_PARITY_EN to exercise the 8E1 variant and parity_err.
module tb_uart_rx;

  localparam int CYC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       rx_ready;
  logic [7:0] dout;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  int         n_acc;
  int         n_vcyc;
  int         n_ferr;
  int         n_ovr;
  int         n_perr;
  logic [7:0] last_acc;

  uart_rx #(.CLK_FRE(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_pin    (rx_pin),
    .dout      (dout),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Event monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) n_vcyc++;
    if (rx_valid && rx_ready) begin
      n_acc++;
      last_acc = dout;
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
  end

  task automatic clear_mon();
    n_acc    = 0;
    n_vcyc   = 0;
    n_ferr   = 0;
    n_ovr    = 0;
    n_perr   = 0;
    last_acc = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    idle(CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
    rx_pin = 1'b1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rx_pin   = 1'b1;
    rx_ready = 1'b0;
    clear_mon();
    #2;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    idle(3);
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_byte_a5();
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    idle(10);
    checks++; if (n_acc !== 1) begin failures++; $display("FAIL a5_accepts got=%0d exp=1", n_acc); end
    checks++; if (last_acc !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", last_acc); end
    checks++; if (n_vcyc !== 1) begin failures++; $display("FAIL a5_valid_cycles got=%0d exp=1", n_vcyc); end
    checks++; if (n_ferr !== 0) begin failures++; $display("FAIL a5_frame_err got=%0d exp=0", n_ferr); end
    checks++; if (n_ovr !== 0) begin failures++; $display("FAIL a5_overrun got=%0d exp=0", n_ovr); end
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    clear_mon();
    rx_pin = 1'b0;
    idle(3);
    rx_pin = 1'b1;
    idle(30);
    checks++; if (n_vcyc !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", n_vcyc); end
    checks++; if (n_ferr !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", n_ferr); end
    checks++; if (n_ovr !== 0) begin failures++; $display("FAIL glitch_overrun got=%0d exp=0", n_ovr); end
  endtask

  task automatic test_frame_err();
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'h3C, 1'b0);
    idle(30);
    checks++; if (n_ferr !== 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", n_ferr); end
    checks++; if (n_vcyc !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", n_vcyc); end
    checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL ferr_dout got=%h exp=a5", dout); end
    checks++; if (n_perr !== 0) begin failures++; $display("FAIL ferr_parity got=%0d exp=0", n_perr); end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1);
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got=%b exp=1", rx_valid); end
    checks++; if (dout !== 8'h11) begin failures++; $display("FAIL ovr_first_dout got=%h exp=11", dout); end
    send_frame(8'h22, 1'b1);
    checks++; if (n_ovr !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", n_ovr); end
    checks++; if (dout !== 8'h11) begin failures++; $display("FAIL ovr_dout_held got=%h exp=11", dout); end
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_drop got=%b exp=0", rx_valid); end
    checks++; if (last_acc !== 8'h11 || n_acc !== 1) begin failures++; $display("FAIL ovr_accept got=%h/%0d exp=11/1", last_acc, n_acc); end
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1);
    // Second byte completes at the 98th edge after its start bit is driven.
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle(3);
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
    checks++; if (dout !== 8'h22) begin failures++; $display("FAIL b2b_dout got=%h exp=22", dout); end
    checks++; if (n_ovr !== 0) begin failures++; $display("FAIL b2b_overrun got=%0d exp=0", n_ovr); end
    checks++; if (last_acc !== 8'h11 || n_acc !== 1) begin failures++; $display("FAIL b2b_first_accept got=%h/%0d exp=11/1", last_acc, n_acc); end
    rx_ready = 1'b1;
    idle(2);
    checks++; if (last_acc !== 8'h22 || n_acc !== 2) begin failures++; $display("FAIL b2b_drain got=%h/%0d exp=22/2", last_acc, n_acc); end
  endtask

  task automatic test_reset_mid_frame();
    rx_ready = 1'b1;
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(20);
    checks++; if (n_vcyc !== 0) begin failures++; $display("FAIL rstmid_no_partial got=%0d exp=0", n_vcyc); end
    send_frame(8'h5A, 1'b1);
    idle(10);
    checks++; if (n_acc !== 1 || last_acc !== 8'h5A) begin failures++; $display("FAIL rstmid_deliver got=%h/%0d exp=5a/1", last_acc, n_acc); end
    checks++; if (n_ferr !== 0) begin failures++; $display("FAIL rstmid_frame_err got=%0d exp=0", n_ferr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity_err();
    rx_ready = 1'b1;
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(8'h5A >> i);
    drive_bit(1'b1);
    drive_bit(1'b1);
    idle(20);
    checks++; if (n_perr !== 1) begin failures++; $display("FAIL parity_pulses got=%0d exp=1", n_perr); end
    checks++; if (n_vcyc !== 0) begin failures++; $display("FAIL parity_valid got=%0d exp=0", n_vcyc); end
    checks++; if (n_ferr !== 0) begin failures++; $display("FAIL parity_frame_err got=%0d exp=0", n_ferr); end
  endtask
`endif

  initial begin
    test_reset();
    test_byte_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 serial receiver for the CPU bus UART; pairs with the existing transmitter at the same CLK_FRE/BAUD_RATE.
- Synchronises the asynchronous rx_pin, detects start bits and samples each bit at mid-period.
- Presents each received byte on a one-entry valid/ready output register to the bus UART peripheral.
- Flags framing errors and overruns.

Parameters:
- CLK_FRE, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial baud rate in bits per second.
- Derived constant CYCLE = CLK_FRE / BAUD_RATE (integer division), clocks per bit. HALF = CYCLE / 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- rx_pin  input  1  serial data input, idle high, asynchronous to clk.
- dout  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  dout holds an unconsumed byte.
- rx_ready  input  1  consumer accepts dout when rx_valid && rx_ready on a rising clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the previous byte was unconsumed.

Behaviour:
- Reset values:
  - Outputs: dout=8'h00, rx_valid=0, frame_err=0, overrun=0.
  - Internal: state=IDLE, bit counter=0, baud counter=0, synchroniser flops=1.
- rx_pin passes through a 2-FF synchroniser giving rx_s; a start edge is rx_s==0 with the previous rx_s==1.
- Baud counter width is $clog2(CYCLE)+1. It is cleared on every state entry and counts up by 1 each clk.
- States:
  - IDLE: on a falling edge of rx_s, clear the counter and go to START.
  - START: when counter==HALF-1, sample rx_s. If 0, clear the counter and go to DATA with bitpos=0. If 1, treat it as a glitch and return to IDLE with no output.
  - DATA: when counter==CYCLE-1, shift rx_s into the shift register LSB first (bit bitpos) and clear the counter. After bitpos==7, go to STOP; otherwise increment bitpos.
  - STOP: when counter==CYCLE-1 (mid stop bit), sample rx_s and go to IDLE the same cycle. This allows back-to-back frames with one stop bit.
- Stop-bit outcomes:
  - rx_s=1: byte complete.
  - rx_s=0: frame_err=1 for one cycle, byte discarded, rx_valid and dout unchanged.
- Byte completion:
  - If rx_valid==0, or rx_valid && rx_ready in the same cycle: dout <= shift register, rx_valid <= 1 (next cycle).
  - If rx_valid==1 and rx_ready==0: new byte dropped, old dout kept, overrun=1 for one cycle.
- Handshake:
  - rx_valid && rx_ready with no completion that cycle: rx_valid <= 0 next cycle.
  - dout is stable while rx_valid=1.
- Latency: rx_valid rises 2 (synchroniser) + 1 clk after the mid-stop-bit sample.
- A line held low (break) produces frame_err, then the receiver waits in IDLE for a new falling edge. Line low on IDLE entry does not retrigger.
- Asserting rst mid-frame aborts the frame immediately. No partial byte is ever presented.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state is inserted between DATA and STOP and samples at counter==CYCLE-1.
  - Extra output parity_err (1 bit, reset 0) pulses one cycle at stop-sample time if XOR of the 8 data bits and the parity bit is 1.
  - On parity error the byte is still discarded.
- Undefined: 8N1 only, no parity_err port.

Decomposition:
- Package uart_pkg:
  - State encodings IDLE/START/DATA/PARITY/STOP (3-bit).
  - Function computing CYCLE/HALF from CLK_FRE and BAUD_RATE.
  - Shared by the transmitter.
- Sub-module uart_rx_sync: 2-FF synchroniser with reset-to-1, plus falling-edge detect output.

Test Plan:
All scenarios use CLK_FRE=1_000_000, BAUD_RATE=100_000 (CYCLE=10, HALF=5).
- Drive 8N1 frame 0xA5 with rx_ready=1 -> rx_valid single-cycle pulse with dout=8'hA5; frame_err=0, overrun=0.
- Low glitch of 3 clks on idle line -> returns to IDLE, no rx_valid, no frame_err.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses once, rx_valid stays 0, dout unchanged.
- rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid=1 with dout=8'h11 held; overrun pulses at end of the second frame. Raise rx_ready -> rx_valid drops the next cycle.
- rx_ready asserted on exactly the cycle the second byte 0x22 completes -> 0x11 accepted, dout=8'h22, rx_valid stays 1, no overrun.
- Assert rst after bit 3 of frame 0xFF, release, then send 0x5A -> only 0x5A delivered. With UART_RX_PARITY_EN, 0x5A with parity bit 1 -> parity_err pulse, no rx_valid.
